// File: rtl/mem_trace_buffer_pkg.sv
// Shared encodings for the RAM write trace buffer: capture FSM states and capture modes.
package mem_trace_buffer_pkg;

    typedef enum logic [1:0] {
        TR_IDLE    = 2'd0,
        TR_CAPTURE = 2'd1,
        TR_STOPPED = 2'd2
    } tr_state_e;

    typedef enum logic {
        TR_WRAP = 1'b0,
        TR_STOP = 1'b1
    } tr_mode_e;

endpackage

// File: rtl/mem_trace_buffer_trace_ram.sv
// Trace entry storage: one write port, one read port whose output register holds
// the last popped entry until the next read.
module trace_ram #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read-before-write: a pop and an overwrite of the same slot return the old entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mem_trace_buffer.sv
// Captures data-RAM write events (pc, address, data) into a circular trace buffer
// drained through a pop interface; wrap or stop-on-full capture modes.
module mem_trace_buffer
    import mem_trace_buffer_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int FILTER_EN  = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       arm,
    input  logic                       mode,
    input  logic                       cap_valid,
    input  logic [PC_WIDTH-1:0]        cap_pc,
    input  logic [ADDR_WIDTH-1:0]      cap_addr,
    input  logic [DATA_WIDTH-1:0]      cap_data,
    input  logic [ADDR_WIDTH-1:0]      filt_lo,
    input  logic [ADDR_WIDTH-1:0]      filt_hi,
    input  logic                       rd_req,
    output logic                       rd_valid,
    output logic [PC_WIDTH-1:0]        rd_pc,
    output logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic [1:0]                 state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = PC_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    tr_state_e        state_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             rd_valid_q;
    logic [ENT_W-1:0] rd_entry;

    logic in_window;
    logic accept;
    logic pop;
    logic is_full;
    logic store;
    logic overwrite;
    logic drop;

    // arm wins over capture and pop in the same cycle, so both are gated by it here.
    always_comb begin
        in_window = (FILTER_EN == 0) || ((cap_addr >= filt_lo) && (cap_addr <= filt_hi));
        accept    = enable && !arm && (state_q == TR_CAPTURE) && cap_valid && in_window;
        pop       = enable && !arm && rd_req && (count_q != '0);
        is_full   = (count_q == FULL_COUNT);
        store     = accept && (!is_full || pop || (mode == TR_WRAP));
        overwrite = accept && is_full && !pop && (mode == TR_WRAP);
        drop      = accept && is_full && !pop && (mode == TR_STOP);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= TR_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else if (!enable) begin
            rd_valid_q <= 1'b0;
        end else if (arm) begin
            state_q    <= TR_CAPTURE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= pop;
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop || overwrite) rd_ptr <= rd_ptr + 1'b1;
            if (store && !pop && !is_full) count_q <= count_q + 1'b1;
            else if (pop && !store)        count_q <= count_q - 1'b1;
            if (overwrite || drop) overflow_q <= 1'b1;
            if (drop) state_q <= TR_STOPPED;
        end
    end

    trace_ram #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_trace_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (store),
        .wr_addr (wr_ptr),
        .wr_data ({cap_pc, cap_addr, cap_data}),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    assign rd_valid = rd_valid_q;
    assign rd_pc    = rd_entry[ENT_W-1 -: PC_WIDTH];
    assign rd_addr  = rd_entry[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
    assign rd_data  = rd_entry[DATA_WIDTH-1:0];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_COUNT);
    assign overflow = overflow_q;
    assign state    = state_q;

endmodule

// File: doc/mem_trace_buffer.md
Name: mem_trace_buffer

Overview:
- Hardware successor to the bench-side RAM write monitor: captures data-RAM write events (pc, address, data) from the CPU into an on-chip circular trace buffer.
- Parametrised in width, depth and address-filter window; two capture modes: wrap (keep newest) and stop-on-full (keep oldest).
- Sits beside Ram on the cpu write path; a debug reader (LED driver, UART, bench) drains it through a pop interface.

Parameters:
- PC_WIDTH, 32, width of captured pc.
- ADDR_WIDTH, 32, width of captured RAM address.
- DATA_WIDTH, 32, width of captured write data.
- DEPTH, 16, entry count; power of two, >= 2.
- FILTER_EN, 1, 1 = apply address window; 0 = capture every write.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  global enable; 0 freezes capture and pop, state held.
- arm  in  1  one-cycle pulse: clear buffer and overflow, enter CAPTURE.
- mode  in  1  0 = wrap/overwrite oldest, 1 = stop when full.
- cap_valid  in  1  RAM write strobe (Ram write_enable).
- cap_pc  in  PC_WIDTH  pc of the storing instruction.
- cap_addr  in  ADDR_WIDTH  RAM address.
- cap_data  in  DATA_WIDTH  RAM data_in.
- filt_lo  in  ADDR_WIDTH  inclusive lower address bound.
- filt_hi  in  ADDR_WIDTH  inclusive upper address bound.
- rd_req  in  1  pop oldest entry.
- rd_valid  out  1  rd_* hold a popped entry this cycle.
- rd_pc  out  PC_WIDTH  popped pc.
- rd_addr  out  ADDR_WIDTH  popped address.
- rd_data  out  DATA_WIDTH  popped data.
- count  out  $clog2(DEPTH+1)  valid entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a write was lost or overwritten.
- state  out  2  0 IDLE, 1 CAPTURE, 2 STOPPED.

Behaviour:
- Reset: state IDLE; wr/rd pointers 0; count 0; empty 1; full 0; overflow 0; rd_valid 0; rd_pc, rd_addr, rd_data all 0. Storage is not cleared.
- enable = 0: no register changes except rd_valid, which drops to 0.
- FSM transitions:
  - IDLE -> CAPTURE on arm.
  - CAPTURE -> STOPPED when mode = 1 and an accepted write arrives while full.
  - STOPPED -> CAPTURE on arm.
  - arm from any state clears pointers, count and overflow.
- Accept: state CAPTURE & cap_valid & (FILTER_EN == 0 or filt_lo <= cap_addr <= filt_hi, unsigned compare). filt_lo > filt_hi accepts nothing.
- Accepted write: entry written at wr_ptr; wr_ptr increments modulo DEPTH; count + 1. Visible on count/empty next cycle (1-cycle latency).
- Full, mode 0: overwrite the oldest entry; both pointers advance; count stays DEPTH; overflow set.
- Full, mode 1: write dropped; overflow set; enter STOPPED.
- Pop: rd_req & !empty. Entry at rd_ptr is registered onto rd_* with rd_valid = 1 the next cycle; rd_ptr increments; count - 1. rd_req when empty is ignored (rd_valid 0 next cycle). rd_* hold their last value when rd_valid = 0.
- Pops are legal in every state, including IDLE after a capture.
- Push and pop in the same cycle:
  - Not full: count unchanged; the popped entry is the pre-push oldest.
  - Full: the pop frees a slot, so the push is stored, no overflow, no STOPPED.
  - Empty: only the push takes effect; rd_valid 0.
- arm in the same cycle as cap_valid/rd_req: arm has priority; that capture is discarded, the pop is ignored, rd_valid 0.
- Reset asserted mid-operation: immediate return to reset values, independent of clock.
- Pointers are $clog2(DEPTH) bits with natural wrap; full/empty derive from count, not pointer compare.

Decomposition:
- Shared package/include (trace_defs): state encodings TR_IDLE/TR_CAPTURE/TR_STOPPED, mode encodings TR_WRAP/TR_STOP.
- One sub-module, trace_ram: DEPTH x (PC_WIDTH+ADDR_WIDTH+DATA_WIDTH) storage with 1 write port, 1 registered read port.
- Control FSM, pointers, filter and flags stay in mem_trace_buffer.

Test Plan:
- DEPTH=4, mode 0, no filter: arm, 6 writes addr 0..5, data A0..A5 -> count 4, overflow 1; pops return addr 2,3,4,5 in order, rd_valid one cycle after each rd_req, then empty 1.
- DEPTH=4, mode 1: arm, 6 writes -> state 2 after 5th write, count 4, overflow 1; pops return addr 0,1,2,3; arm -> state 1, count 0, overflow 0.
- Filter lo=0x10, hi=0x1F: writes at 0x0F, 0x10, 0x1F, 0x20 -> count 2, entries 0x10 and 0x1F.
- Full + simultaneous push/pop (mode 1): pop returns oldest, new entry stored, count 4, overflow 0, state stays 1. Same-cycle arm + cap_valid -> count 0. rd_req while empty -> rd_valid 0.
- Reset low mid-capture with count 3 -> count 0, state 0, rd_valid 0 without a clock edge. enable 0 with cap_valid -> count unchanged.
